outmap_writer: RTL and testbench

Downstream consumer of the output buffer. Drains packed output-map bytes (up to 16 per cycle) through the outmap_data / outmap_data_valid_num / valid_taken_num handshake. Stages them in a 32-byte byte-FIFO and emits 64-bit, byte-strobed memory write beats to sequential addresses from a per-layer base address. On send_done it flushes any partial final beat and pulses done.

---
 rtl/outmap_writer.sv | 151 +++++++++++++++
 tb/tb_outmap_writer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outmap_writer.sv
// Drains packed output-map bytes into a 32-byte staging FIFO and writes them out as
// 64-bit byte-strobed beats to sequential addresses, flushing a partial last beat on send_done.
module outmap_writer #(
  parameter int BEAT_BYTES  = 8,
  parameter int STAGE_BYTES = 32,
  parameter int ADDR_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0][7:0]       outmap_data,
  input  logic [4:0]             outmap_data_valid_num,
  output logic [4:0]             valid_taken_num,
  input  logic                   send_done,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic                   mem_wr_valid,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic [63:0]            mem_wr_data,
  output logic [7:0]             mem_wr_strb,
  input  logic                   mem_wr_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = $clog2(STAGE_BYTES + 1);
  localparam int IDX_W = $clog2(STAGE_BYTES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [STAGE_BYTES-1:0][7:0]  stage_q, stage_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic                         wr_vld_q, wr_vld_d;
  logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
  logic [63:0]                  wr_data_q, wr_data_d;
  logic [7:0]                   wr_strb_q, wr_strb_d;

  logic [CNT_W-1:0]             in_num;
  logic [CNT_W-1:0]             space;
  logic [CNT_W-1:0]             take;
  logic [CNT_W-1:0]             pop;
  logic                         can_load;
  logic [63:0]                  beat_data;
  logic [7:0]                   beat_strb;
  int                           src;
  int                           k;

  always_comb begin
    in_num = (outmap_data_valid_num > 5'd16) ? CNT_W'(16) : CNT_W'(outmap_data_valid_num);
    space  = CNT_W'(STAGE_BYTES) - count_q;
    take   = '0;
    if (state_q == S_RUN) take = (in_num < space) ? in_num : space;
    valid_taken_num = take[4:0];

    // Pops are decided from the registered count, so a byte always sits in staging for a cycle.
    can_load = !wr_vld_q || mem_wr_ready;
    pop = '0;
    if (can_load) begin
      if (state_q == S_RUN && count_q >= CNT_W'(BEAT_BYTES)) begin
        pop = CNT_W'(BEAT_BYTES);
      end else if (state_q == S_FLUSH && count_q != '0) begin
        pop = (count_q < CNT_W'(BEAT_BYTES)) ? count_q : CNT_W'(BEAT_BYTES);
      end
    end

    beat_data = '0;
    beat_strb = '0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      if (j < int'(pop)) begin
        beat_data[8*j +: 8] = stage_q[j[IDX_W-1:0]];
        beat_strb[j]        = 1'b1;
      end
    end

    // Survivors shift down by pop; new bytes land right after them.
    src = 0;
    k   = 0;
    for (int i = 0; i < STAGE_BYTES; i++) begin
      stage_d[i[IDX_W-1:0]] = 8'h00;
      src = i + int'(pop);
      k   = i + int'(pop) - int'(count_q);
      if (src < int'(count_q)) begin
        stage_d[i[IDX_W-1:0]] = stage_q[src[IDX_W-1:0]];
      end else if (k >= 0 && k < int'(take)) begin
        stage_d[i[IDX_W-1:0]] = outmap_data[k[3:0]];
      end
    end
    count_d = count_q + take - pop;

    wr_vld_d  = wr_vld_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    addr_d    = addr_q;
    if (wr_vld_q && mem_wr_ready) wr_vld_d = 1'b0;
    if (pop != '0) begin
      wr_vld_d  = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = beat_data;
      wr_strb_d = beat_strb;
      addr_d    = addr_q + ADDR_W'(BEAT_BYTES);
    end

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = base_addr;
        end
      end
      S_RUN:   if (send_done) state_d = S_FLUSH;
      S_FLUSH: if (count_q == '0 && can_load) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      stage_q   <= '0;
      addr_q    <= '0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      stage_q   <= stage_d;
      addr_q    <= addr_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
    end
  end

  assign mem_wr_valid = wr_vld_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;
  assign mem_wr_strb  = wr_strb_q;
  assign busy         = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_outmap_writer.sv
// Scoreboard bench for outmap_writer: expected beats are queued when bytes are offered
// and checked against every accepted memory write.
module tb_outmap_writer;

  logic              clk;
  logic              rst_n;
  logic [15:0][7:0]  outmap_data;
  logic [4:0]        outmap_data_valid_num;
  logic [4:0]        valid_taken_num;
  logic              send_done;
  logic              start;
  logic [31:0]       base_addr;
  logic              mem_wr_valid;
  logic [31:0]       mem_wr_addr;
  logic [63:0]       mem_wr_data;
  logic [7:0]        mem_wr_strb;
  logic              mem_wr_ready;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int failures = 0;

  outmap_writer #(.BEAT_BYTES(8), .STAGE_BYTES(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .outmap_data(outmap_data), .outmap_data_valid_num(outmap_data_valid_num),
    .valid_taken_num(valid_taken_num), .send_done(send_done), .start(start),
    .base_addr(base_addr), .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb), .mem_wr_ready(mem_wr_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beats for a byte stream written from base: 8-byte beats, last one partial.
  function automatic void push_beats(input logic [31:0] base, input logic [7:0] bq[$]);
    int nb;
    beat_t b;
    nb = (bq.size() + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      b.a = base + 32'(8 * i);
      b.d = '0;
      b.s = '0;
      for (int j = 0; j < 8; j++) begin
        if (8 * i + j < bq.size()) begin
          b.d[8*j +: 8] = bq[8*i + j];
          b.s[j] = 1'b1;
        end
      end
      sb.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && mem_wr_valid && mem_wr_ready) begin
      beat_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat addr=%h data=%h strb=%h", mem_wr_addr, mem_wr_data, mem_wr_strb);
      end else begin
        e = sb.pop_front();
        if (mem_wr_addr !== e.a) begin
          failures++;
          $display("FAIL beat_addr got=%h exp=%h", mem_wr_addr, e.a);
        end
        checks++;
        if (mem_wr_data !== e.d) begin
          failures++;
          $display("FAIL beat_data got=%h exp=%h", mem_wr_data, e.d);
        end
        checks++;
        if (mem_wr_strb !== e.s) begin
          failures++;
          $display("FAIL beat_strb got=%h exp=%h", mem_wr_strb, e.s);
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] base);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_send_done();
    outmap_data_valid_num = 5'd0;
    send_done = 1'b1;
    @(posedge clk); #1;
    send_done = 1'b0;
  endtask

  task automatic drive_stream(input logic [7:0] bq[$], input int chunk);
    int idx = 0;
    int cyc = 0;
    int n;
    while (idx < bq.size() && cyc < 200) begin
      n = (bq.size() - idx < chunk) ? bq.size() - idx : chunk;
      for (int k = 0; k < 16; k++) outmap_data[k] = (k < n) ? bq[idx + k] : 8'h00;
      outmap_data_valid_num = 5'(n);
      @(negedge clk);
      n = int'(valid_taken_num);
      @(posedge clk); #1;
      idx += n;
      cyc++;
    end
    outmap_data_valid_num = 5'd0;
    checks++;
    if (idx != bq.size()) begin
      failures++;
      $display("FAIL stream_timeout sent=%0d exp=%0d", idx, bq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    outmap_data = '0;
    for (int k = 0; k < 16; k++) outmap_data[k] = 8'(k + 1);
    outmap_data_valid_num = 5'd16;
    send_done = 1'b0;
    start = 1'b0;
    base_addr = 32'h0;
    mem_wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_wr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", mem_wr_valid); end
    checks++; if (mem_wr_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", mem_wr_addr); end
    checks++; if (mem_wr_data !== 64'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", mem_wr_data); end
    checks++; if (mem_wr_strb !== 8'h0) begin failures++; $display("FAIL rst_strb got=%h exp=0", mem_wr_strb); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (valid_taken_num !== 5'd0) begin failures++; $display("FAIL rst_taken got=%0d exp=0", valid_taken_num); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (valid_taken_num !== 5'd0) begin failures++; $display("FAIL idle_taken got=%0d exp=0", valid_taken_num); end
    @(posedge clk); #1;
    outmap_data_valid_num = 5'd0;
  endtask

  task automatic test_basic();
    logic [7:0] bq[$];
    int nd = 0;
    for (int i = 0; i < 16; i++) bq.push_back(8'(i));
    push_beats(32'h1000, bq);
    mem_wr_ready = 1'b1;
    do_start(32'h1000);
    for (int k = 0; k < 16; k++) outmap_data[k] = bq[k];
    outmap_data_valid_num = 5'd16;
    @(negedge clk);
    checks++; if (valid_taken_num !== 5'd16) begin failures++; $display("FAIL basic_taken got=%0d exp=16", valid_taken_num); end
    @(posedge clk); #1;
    outmap_data_valid_num = 5'd0;
    send_done = 1'b1;
    @(negedge clk);
    checks++; if (mem_wr_valid !== 1'b0) begin failures++; $display("FAIL basic_latency valid=%b exp=0", mem_wr_valid); end
    @(posedge clk); #1;
    send_done = 1'b0;
    repeat (30) begin @(negedge clk); if (done) nd++; end
    checks++; if (nd != 1) begin failures++; $display("FAIL basic_done pulses=%0d exp=1", nd); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_beats missing=%0d exp=0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_partial();
    logic [7:0] bq[$];
    int nd = 0;
    for (int i = 0; i < 11; i++) bq.push_back(8'(8'hA0 + i));
    push_beats(32'h1000, bq);
    do_start(32'h1000);
    drive_stream(bq, 16);
    pulse_send_done();
    repeat (30) begin @(negedge clk); if (done) nd++; end
    checks++; if (nd != 1) begin failures++; $display("FAIL partial_done pulses=%0d exp=1", nd); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL partial_beats missing=%0d exp=0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] bq[$];
    logic [7:0] rest[$];
    int exp_take[4] = '{16, 16, 8, 0};
    int idx = 0;
    int nd = 0;
    logic [63:0] d0;
    for (int i = 0; i < 48; i++) bq.push_back(8'(i * 3 + 7));
    push_beats(32'h4000, bq);
    for (int j = 0; j < 8; j++) d0[8*j +: 8] = bq[j];
    mem_wr_ready = 1'b0;
    do_start(32'h4000);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 16; k++) outmap_data[k] = bq[idx + k];
      outmap_data_valid_num = 5'd16;
      @(negedge clk);
      checks++;
      if (int'(valid_taken_num) != exp_take[c]) begin
        failures++;
        $display("FAIL bp_taken cycle=%0d got=%0d exp=%0d", c, valid_taken_num, exp_take[c]);
      end
      idx += int'(valid_taken_num);
      @(posedge clk); #1;
    end
    outmap_data_valid_num = 5'd0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h4000 || mem_wr_data !== d0 || mem_wr_strb !== 8'hFF) begin
        failures++;
        $display("FAIL bp_stall v=%b addr=%h data=%h strb=%h exp 1 4000 %h ff", mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb, d0);
      end
    end
    @(posedge clk); #1;
    mem_wr_ready = 1'b1;
    for (int i = idx; i < 48; i++) rest.push_back(bq[i]);
    drive_stream(rest, 16);
    pulse_send_done();
    repeat (40) begin @(negedge clk); if (done) nd++; end
    checks++; if (nd != 1) begin failures++; $display("FAIL bp_done pulses=%0d exp=1", nd); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_beats missing=%0d exp=0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_uneven();
    logic [7:0] bq[$];
    int chunks[5] = '{3, 5, 7, 1, 20};
    int off = 0;
    int n;
    int nd = 0;
    for (int i = 0; i < 32; i++) bq.push_back(8'(8'h40 + i));
    push_beats(32'h5000, bq);
    mem_wr_ready = 1'b1;
    do_start(32'h5000);
    for (int c = 0; c < 5; c++) begin
      n = (chunks[c] > 16) ? 16 : chunks[c];
      for (int k = 0; k < 16; k++) outmap_data[k] = (k < n) ? bq[off + k] : 8'h00;
      outmap_data_valid_num = 5'(chunks[c]);
      @(negedge clk);
      checks++;
      if (int'(valid_taken_num) != n) begin
        failures++;
        $display("FAIL uneven_taken vn=%0d got=%0d exp=%0d", chunks[c], valid_taken_num, n);
      end
      off += n;
      @(posedge clk); #1;
    end
    pulse_send_done();
    repeat (30) begin @(negedge clk); if (done) nd++; end
    checks++; if (nd != 1) begin failures++; $display("FAIL uneven_done pulses=%0d exp=1", nd); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL uneven_beats missing=%0d exp=0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    do_start(32'h6000);
    pulse_send_done();
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL empty_flush done=%b busy=%b exp 0 1", done, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL empty_done got=%b exp=1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL empty_idle done=%b busy=%b exp 0 0", done, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] bq[$];
    int nd = 0;
    mem_wr_ready = 1'b0;
    do_start(32'h3000);
    for (int k = 0; k < 16; k++) outmap_data[k] = 8'(8'h90 + k);
    outmap_data_valid_num = 5'd16;
    @(posedge clk); #1;
    outmap_data_valid_num = 5'd12;
    @(posedge clk); #1;
    outmap_data_valid_num = 5'd0;
    @(negedge clk);
    checks++; if (mem_wr_valid !== 1'b1) begin failures++; $display("FAIL mid_pending got=%b exp=1", mem_wr_valid); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    outmap_data_valid_num = 5'd16;
    #1;
    checks++;
    if (mem_wr_valid !== 1'b0 || mem_wr_addr !== 32'h0 || mem_wr_data !== 64'h0 || mem_wr_strb !== 8'h0 ||
        busy !== 1'b0 || done !== 1'b0 || valid_taken_num !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset v=%b a=%h d=%h s=%h busy=%b done=%b taken=%0d exp all 0",
               mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_strb, busy, done, valid_taken_num);
    end
    outmap_data_valid_num = 5'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) bq.push_back(8'(8'hC0 + i));
    push_beats(32'h2000, bq);
    do_start(32'h2000);
    drive_stream(bq, 16);
    pulse_send_done();
    repeat (30) begin @(negedge clk); if (done) nd++; end
    checks++; if (nd != 1) begin failures++; $display("FAIL mid_done pulses=%0d exp=1", nd); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL mid_beats missing=%0d exp=0", sb.size()); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_uneven();
    test_empty();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
